// File: rtl/centroid_tx.sv
// Object centroid measurement: accumulates hit-pixel coordinates per frame and
// divides by the hit count to emit one (z_x, z_y) measurement per frame.
module centroid_tx #(
  parameter int DISP_WIDTH = 11,
  parameter int SUM_WIDTH  = 32,
  parameter int CNT_WIDTH  = 21
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DISP_WIDTH-1:0] pix_x,
  input  logic [DISP_WIDTH-1:0] pix_y,
  input  logic                  pix_valid,
  input  logic                  pix_hit,
  input  logic                  frame_end,
  output logic [DISP_WIDTH-1:0] z_x,
  output logic [DISP_WIDTH-1:0] z_y,
  output logic                  valid,
  input  logic                  ready,
  output logic                  frame_empty,
  output logic                  overrun
);

  localparam int BW = $clog2(SUM_WIDTH + 1);

  typedef enum logic [1:0] {IDLE, DIVIDE, SEND} state_t;

  state_t                state_q, state_d;
  logic [SUM_WIDTH-1:0]  sum_x, sum_y, sum_x_tot, sum_y_tot;
  logic [CNT_WIDTH-1:0]  cnt, cnt_tot;
  logic                  hit_en, start, div_done;
  logic [SUM_WIDTH-1:0]  qx, qy;
  logic [CNT_WIDTH-1:0]  rx, ry, divisor;
  logic [BW-1:0]         bit_cnt;

  // Handshake: a measurement transfers on a cycle with valid=1 and ready=1;
  // z_x/z_y stay stable while valid=1 and ready=0.

  // One restoring-division step: returns {remainder, quotient/dividend shift}.
  function automatic logic [CNT_WIDTH+SUM_WIDTH-1:0] div_step(
    input logic [SUM_WIDTH-1:0] q,
    input logic [CNT_WIDTH-1:0] r,
    input logic [CNT_WIDTH-1:0] d
  );
    logic [CNT_WIDTH:0] trial;
    logic [CNT_WIDTH:0] diff;
    trial = {r, q[SUM_WIDTH-1]};
    diff  = trial - {1'b0, d};
    if (trial >= {1'b0, d})
      div_step = {diff[CNT_WIDTH-1:0], q[SUM_WIDTH-2:0], 1'b1};
    else
      div_step = {trial[CNT_WIDTH-1:0], q[SUM_WIDTH-2:0], 1'b0};
  endfunction

  // Saturated counter ignores further hits until the frame ends.
  assign hit_en    = pix_valid & pix_hit & ~(&cnt);
  assign sum_x_tot = sum_x + (hit_en ? SUM_WIDTH'(pix_x) : '0);
  assign sum_y_tot = sum_y + (hit_en ? SUM_WIDTH'(pix_y) : '0);
  assign cnt_tot   = cnt + CNT_WIDTH'(hit_en);
  assign start     = frame_end && (state_q == IDLE) && (cnt_tot != '0);
  assign div_done  = (bit_cnt == BW'(SUM_WIDTH));
  assign valid     = (state_q == SEND);

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = DIVIDE;
      DIVIDE:  if (div_done) state_d = SEND;
      SEND:    if (ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sum_x       <= '0;
      sum_y       <= '0;
      cnt         <= '0;
      qx          <= '0;
      qy          <= '0;
      rx          <= '0;
      ry          <= '0;
      divisor     <= '0;
      bit_cnt     <= '0;
      z_x         <= '0;
      z_y         <= '0;
      frame_empty <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      // Accumulators clear on every frame_end, whether or not the frame is kept.
      sum_x       <= frame_end ? '0 : sum_x_tot;
      sum_y       <= frame_end ? '0 : sum_y_tot;
      cnt         <= frame_end ? '0 : cnt_tot;
      frame_empty <= frame_end && (state_q == IDLE) && (cnt_tot == '0);
      overrun     <= frame_end && (state_q != IDLE);
      if (start) begin
        qx      <= sum_x_tot;
        qy      <= sum_y_tot;
        rx      <= '0;
        ry      <= '0;
        divisor <= cnt_tot;
        bit_cnt <= '0;
      end else if (state_q == DIVIDE && !div_done) begin
        {rx, qx} <= div_step(qx, rx, divisor);
        {ry, qy} <= div_step(qy, ry, divisor);
        bit_cnt  <= bit_cnt + BW'(1);
      end
      if (state_q == DIVIDE && div_done) begin
        z_x <= qx[DISP_WIDTH-1:0];
        z_y <= qy[DISP_WIDTH-1:0];
      end
    end
  end

endmodule

// File: tb/tb_centroid_tx.sv
// Bench for centroid_tx: directed latency/hold/empty/reset scenarios plus
// random frames checked against an arithmetic mean model.
module tb_centroid_tx;

  localparam int DW = 11;
  localparam int W  = 2 * DW;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] pix_x, pix_y;
  logic          pix_valid, pix_hit, frame_end;
  logic [DW-1:0] z_x, z_y;
  logic          valid, ready, frame_empty, overrun;

  logic [W-1:0]  exp_q[$];
  int            n_vec = 0;
  int            n_err = 0;
  int            fe_cnt = 0;
  int            ov_cnt = 0;
  bit            rand_ready = 0;

  centroid_tx dut (
    .clk(clk), .reset(reset), .pix_x(pix_x), .pix_y(pix_y),
    .pix_valid(pix_valid), .pix_hit(pix_hit), .frame_end(frame_end),
    .z_x(z_x), .z_y(z_y), .valid(valid), .ready(ready),
    .frame_empty(frame_empty), .overrun(overrun)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // driver tasks
  task automatic pix(input logic [DW-1:0] x, input logic [DW-1:0] y,
                     input logic v, input logic h, input logic fe);
    pix_x = x; pix_y = y; pix_valid = v; pix_hit = h; frame_end = fe;
    tick();
    pix_valid = 0; pix_hit = 0; frame_end = 0;
  endtask

  function automatic logic [W-1:0] mean_of(input longint sx, input longint sy, input longint n);
    logic [DW-1:0] ex, ey;
    ex = DW'(sx / n);
    ey = DW'(sy / n);
    return {ex, ey};
  endfunction

  // Random frame: len cycles, frame_end on the last one; returns model totals.
  task automatic run_frame(input int len, input int hit_pct,
                           output longint sx, output longint sy, output longint n);
    logic [DW-1:0] x, y;
    logic h;
    sx = 0; sy = 0; n = 0;
    for (int i = 0; i < len; i++) begin
      x = DW'($urandom_range(0, 2047));
      y = DW'($urandom_range(0, 2047));
      h = ($urandom_range(0, 99) < hit_pct);
      if (h) begin sx += x; sy += y; n++; end
      pix(x, y, 1'b1, h, i == len - 1);
    end
  endtask

  task automatic wait_valid();
    int k;
    k = 0;
    while (!valid && k < 100) begin tick(); k++; end
    check_val("wait_valid_timeout", valid, 1);
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while ((exp_q.size() != 0 || valid) && k < 600) begin tick(); k++; end
    check_val("drain_timeout", exp_q.size(), 0);
    tick();
    tick();
  endtask

  always @(posedge clk) begin
    if (rand_ready) begin
      #1 ready = 1'($urandom_range(0, 1));
    end
  end

  // scoreboard / monitor, sampled on the falling edge
  bit            hs_prev = 0, hold_prev = 0;
  logic [DW-1:0] zx_prev, zy_prev;
  always @(negedge clk) begin
    if (reset) begin
      hs_prev = 0; hold_prev = 0;
    end else begin
      if (hs_prev) check_val("valid_drop", valid, 0);
      if (hold_prev && valid) begin
        check_val("hold_z_x", z_x, zx_prev);
        check_val("hold_z_y", z_y, zy_prev);
      end
      if (valid && ready) begin
        if (exp_q.size() == 0) check_val("unexpected_valid", valid, 0);
        else begin
          logic [W-1:0] e;
          e = exp_q.pop_front();
          check_val("z_x", z_x, e[W-1:DW]);
          check_val("z_y", z_y, e[DW-1:0]);
        end
      end
      if (frame_empty) fe_cnt++;
      if (overrun) ov_cnt++;
      if (frame_empty || overrun) check_val("pulse_excl", frame_empty & overrun, 0);
      hs_prev = valid && ready;
      hold_prev = valid && !ready;
      zx_prev = z_x; zy_prev = z_y;
    end
  end

  initial begin
    longint sx, sy, n;
    int fe0, ov0;
    reset = 1; ready = 0; pix_x = 0; pix_y = 0; pix_valid = 0; pix_hit = 0; frame_end = 0;
    repeat (3) tick();
    reset = 0;
    repeat (10) tick();
    check_val("rst_valid", valid, 0);
    check_val("rst_z_x", z_x, 0);
    check_val("rst_z_y", z_y, 0);
    check_val("rst_frame_empty", frame_empty, 0);
    check_val("rst_overrun", overrun, 0);

    // three hits, exact latency with ready held high
    ready = 1;
    pix(10, 20, 1, 1, 0);
    pix(11, 21, 1, 1, 0);
    pix(13, 22, 1, 1, 1);
    exp_q.push_back(mean_of(34, 63, 3));
    repeat (32) tick();
    check_val("lat_valid_early", valid, 0);
    tick();
    check_val("lat_valid", valid, 1);
    check_val("lat_z_x", z_x, 11);
    check_val("lat_z_y", z_y, 21);
    tick();
    check_val("lat_valid_low", valid, 0);
    tick();

    // held measurement with an overrunning frame during SEND
    ready = 0;
    pix(10, 20, 1, 1, 0);
    pix(11, 21, 1, 1, 0);
    pix(13, 22, 1, 1, 1);
    exp_q.push_back(mean_of(34, 63, 3));
    wait_valid();
    ov0 = ov_cnt;
    repeat (20) tick();
    pix(1, 1, 1, 1, 1);
    repeat (79) tick();
    check_val("hold_overrun", ov_cnt - ov0, 1);
    check_val("hold_valid", valid, 1);
    check_val("hold_zx_final", z_x, 11);
    check_val("hold_zy_final", z_y, 21);
    ready = 1;
    tick();
    check_val("hold_release", valid, 0);
    check_val("hold_drained", exp_q.size(), 0);

    // empty frame
    fe0 = fe_cnt;
    for (int i = 0; i < 5; i++) pix(DW'(i), DW'(i), 1, 0, i == 4);
    repeat (40) tick();
    check_val("empty_pulse", fe_cnt - fe0, 1);
    check_val("empty_valid", valid, 0);

    // corner coordinate
    pix(2047, 0, 1, 1, 1);
    exp_q.push_back(mean_of(2047, 0, 1));
    wait_idle();
    check_val("corner_z_x", z_x, 2047);

    // reset mid-divide
    pix(100, 100, 1, 1, 1);
    repeat (9) tick();
    reset = 1;
    tick();
    reset = 0;
    check_val("mid_rst_z_x", z_x, 0);
    repeat (60) tick();
    check_val("mid_rst_valid", valid, 0);
    pix(5, 6, 1, 1, 1);
    exp_q.push_back(mean_of(5, 6, 1));
    wait_idle();
    check_val("post_rst_z_y", z_y, 6);

    // random frames
    rand_ready = 1;
    for (int f = 0; f < 40; f++) begin
      wait_idle();
      fe0 = fe_cnt;
      ov0 = ov_cnt;
      run_frame($urandom_range(1, 12), ($urandom_range(0, 4) == 0) ? 0 : 60, sx, sy, n);
      if (n == 0) begin
        tick();
        check_val("rnd_empty", fe_cnt - fe0, 1);
      end else begin
        exp_q.push_back(mean_of(sx, sy, n));
        if ($urandom_range(0, 2) == 0) begin
          run_frame($urandom_range(1, 6), 50, sx, sy, n);
          tick();
          check_val("rnd_overrun", ov_cnt - ov0, 1);
        end
      end
    end
    wait_idle();
    rand_ready = 0;
    check_val("final_drain", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
